load_store_unit: RTL

//   Sits directly upstream of DataMemory and is its only master.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_if.sv | 43 ++++
 rtl/lsu_addr_gen.sv | 21 ++
 rtl/load_store_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int LSU_ADDR_W = 12;  // DataMemory word-address width (4096 words)
   localparam int LAT_W      = 2;   // wide enough for READ_LATENCY-1 up to 3

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake and DataMemory pins of the load/store unit.
// slave = LSU side, master = execute/writeback stage plus DataMemory.
interface lsu_if #(parameter int ADDR_W = 12);

   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [31:0]       req_base;
   logic [31:0]       req_offset;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;

   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_data;
   logic [4:0]        resp_rd;
   logic              resp_err;

   logic [ADDR_W-1:0] MemAddr;
   logic [31:0]       MemDataIn;
   logic [31:0]       MemDataOut;
   logic              MemEna;
   logic              MemWea;

   modport slave (
      input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
      output req_ready,
      output resp_valid, resp_data, resp_rd, resp_err,
      input  resp_ready,
      output MemAddr, MemDataIn, MemEna, MemWea,
      input  MemDataOut
   );

   modport master (
      output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
      input  req_ready,
      input  resp_valid, resp_data, resp_rd, resp_err,
      output resp_ready,
      input  MemAddr, MemDataIn, MemEna, MemWea,
      output MemDataOut
   );

endinterface

// File: rtl/lsu_addr_gen.sv
// Effective-address generation: byte ea = base + offset (wraps at 32 bits),
// word address and the two fault flags.
module lsu_addr_gen
   import lsu_pkg::*;
#(
   parameter int ADDR_W = LSU_ADDR_W
) (
   input  logic [31:0]       base,
   input  logic [31:0]       offset,
   output logic [31:0]       ea,
   output logic [ADDR_W-1:0] waddr,
   output logic              misaligned,
   output logic              out_of_range
);

   assign ea           = base + offset;
   assign waddr        = ea[ADDR_W+1:2];
   assign misaligned   = |ea[1:0];
   assign out_of_range = |ea[31:ADDR_W+2];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sole master of DataMemory. One request at a time;
// IDLE -> ACCESS -> (WAIT) -> RESP, errors go straight IDLE -> RESP.
// Optional macro LSU_RANGE_CHECK_EN: reject addresses beyond the memory
// instead of wrapping them modulo the memory size.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W       = LSU_ADDR_W,
   parameter int READ_LATENCY = 1
) (
   input logic Clk,
   input logic Rst_n,
   lsu_if.slave bus
);

   lsu_state_e        state, state_n;
   logic [LAT_W-1:0]  cnt;
   logic              is_store_q;

   logic [31:0]       ea_unused;
   logic [ADDR_W-1:0] waddr;
   logic              misaligned;
   logic              out_of_range;
   logic              err;

   logic              mem_ena, mem_wea;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic [31:0]       resp_data;
   logic [4:0]        resp_rd;
   logic              resp_err;

   lsu_addr_gen #(.ADDR_W(ADDR_W)) u_agen (
      .base         (bus.req_base),
      .offset       (bus.req_offset),
      .ea           (ea_unused),
      .waddr        (waddr),
      .misaligned   (misaligned),
      .out_of_range (out_of_range)
   );

`ifdef LSU_RANGE_CHECK_EN
   assign err = misaligned | out_of_range;
`else
   // Upper address bits are ignored; the word address simply wraps.
   logic oor_unused;
   assign oor_unused = out_of_range;
   assign err        = misaligned;
`endif

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Next-state decode.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (bus.req_valid) state_n = err ? ST_RESP : ST_ACCESS;
         ST_ACCESS: state_n = is_store_q ? ST_RESP : ST_WAIT;
         ST_WAIT:   if (cnt == '0) state_n = ST_RESP;
         ST_RESP:   if (bus.resp_ready) state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // Request latch, registered memory pins, latency counter and response.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         is_store_q <= 1'b0;
         mem_ena    <= 1'b0;
         mem_wea    <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         cnt        <= '0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (bus.req_valid) begin
               is_store_q <= bus.req_is_store;
               resp_rd    <= bus.req_rd;
               resp_err   <= err;
               resp_data  <= '0;
               if (!err) begin
                  mem_ena  <= 1'b1;
                  mem_wea  <= bus.req_is_store;
                  mem_addr <= waddr;
                  mem_din  <= bus.req_wdata;
               end
            end
            ST_ACCESS: begin
               // Memory samples on this edge; the enables are one-cycle pulses.
               mem_ena <= 1'b0;
               mem_wea <= 1'b0;
               cnt     <= LAT_W'(READ_LATENCY - 1);
            end
            ST_WAIT: begin
               if (cnt == '0) resp_data <= bus.MemDataOut;
               else           cnt       <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_data  = resp_data;
   assign bus.resp_rd    = resp_rd;
   assign bus.resp_err   = resp_err;
   assign bus.MemEna     = mem_ena;
   assign bus.MemWea     = mem_wea;
   assign bus.MemAddr    = mem_addr;
   assign bus.MemDataIn  = mem_din;

endmodule
